// File: rtl/alu_result_checker.sv
// alu_result_checker: two-stage ALU result monitor with pass/fail/unknown counters and first-failure capture (optional Zero check: ALU_CHECK_ZERO_EN)
module alu_result_checker #(
  parameter int CNT_WIDTH = 16
) (
  input  logic                 Clk,
  input  logic                 Rst,
  input  logic                 Clear,
  input  logic                 InValid,
  input  logic [4:0]           ALUControl,
  input  logic [31:0]          A,
  input  logic [31:0]          B,
  input  logic [31:0]          ALUResult,
  input  logic                 Zero,
  output logic [CNT_WIDTH-1:0] PassCount,
  output logic [CNT_WIDTH-1:0] FailCount,
  output logic [CNT_WIDTH-1:0] UnknownCount,
  output logic                 Mismatch,
  output logic                 Failed,
  output logic [4:0]           FirstFailOp,
  output logic [31:0]          FirstFailGot,
  output logic [31:0]          FirstFailExp
);
  logic                 v1_q, v1_d, z1_q, z1_d;
  logic [4:0]           op1_q, op1_d;
  logic [31:0]          a1_q, a1_d, b1_q, b1_d, res1_q, res1_d;
  logic [CNT_WIDTH-1:0] pass_q, pass_d, fail_q, fail_d, unk_q, unk_d;
  logic                 mis_q, mis_d, failed_q, failed_d;
  logic [4:0]           ff_op_q, ff_op_d;
  logic [31:0]          ff_got_q, ff_got_d, ff_exp_q, ff_exp_d;
  logic [31:0]          exp_res;
  logic                 known, zero_bad, bad, good, unk, first;
  // Expected result of the stage-1 transaction and its pass/fail/unknown verdict
  always_comb begin
    exp_res = op1_q == 5'b00000 ? a1_q & b1_q :
              op1_q == 5'b00001 ? a1_q | b1_q :
              op1_q == 5'b00010 ? a1_q + b1_q :
              op1_q == 5'b00110 ? a1_q - b1_q :
              op1_q == 5'b00111 ? {31'd0, $signed(a1_q) < $signed(b1_q)} : 32'd0;
    known = op1_q inside {5'b00000, 5'b00001, 5'b00010, 5'b00110, 5'b00111};
`ifdef ALU_CHECK_ZERO_EN
    zero_bad = z1_q != (exp_res == 32'd0);
`else
    zero_bad = 1'b0 && z1_q;
`endif
    bad   = v1_q && known && (res1_q != exp_res || zero_bad);
    good  = v1_q && known && !bad;
    unk   = v1_q && !known;
    first = bad && !failed_q;
  end
  // Next state: stage-1 capture, saturating counters, sticky first-failure capture; Clear wins
  always_comb begin
    v1_d     = !Clear && InValid;
    op1_d    = ALUControl;
    a1_d     = A;
    b1_d     = B;
    res1_d   = ALUResult;
    z1_d     = Zero;
    pass_d   = Clear ? '0 : good && pass_q != '1 ? pass_q + 1'b1 : pass_q;
    fail_d   = Clear ? '0 : bad && fail_q != '1 ? fail_q + 1'b1 : fail_q;
    unk_d    = Clear ? '0 : unk && unk_q != '1 ? unk_q + 1'b1 : unk_q;
    mis_d    = !Clear && bad;
    failed_d = !Clear && (failed_q || bad);
    ff_op_d  = Clear ? 5'd0 : first ? op1_q : ff_op_q;
    ff_got_d = Clear ? 32'd0 : first ? res1_q : ff_got_q;
    ff_exp_d = Clear ? 32'd0 : first ? exp_res : ff_exp_q;
  end
  // State registers; reset clears everything asynchronously and drops any in-flight transaction
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      v1_q     <= 1'b0;
      op1_q    <= 5'd0;
      a1_q     <= 32'd0;
      b1_q     <= 32'd0;
      res1_q   <= 32'd0;
      z1_q     <= 1'b0;
      pass_q   <= '0;
      fail_q   <= '0;
      unk_q    <= '0;
      mis_q    <= 1'b0;
      failed_q <= 1'b0;
      ff_op_q  <= 5'd0;
      ff_got_q <= 32'd0;
      ff_exp_q <= 32'd0;
    end else begin
      v1_q     <= v1_d;
      op1_q    <= op1_d;
      a1_q     <= a1_d;
      b1_q     <= b1_d;
      res1_q   <= res1_d;
      z1_q     <= z1_d;
      pass_q   <= pass_d;
      fail_q   <= fail_d;
      unk_q    <= unk_d;
      mis_q    <= mis_d;
      failed_q <= failed_d;
      ff_op_q  <= ff_op_d;
      ff_got_q <= ff_got_d;
      ff_exp_q <= ff_exp_d;
    end
  end
  assign PassCount    = pass_q;
  assign FailCount    = fail_q;
  assign UnknownCount = unk_q;
  assign Mismatch     = mis_q;
  assign Failed       = failed_q;
  assign FirstFailOp  = ff_op_q;
  assign FirstFailGot = ff_got_q;
  assign FirstFailExp = ff_exp_q;
endmodule

// File: tb/tb_alu_result_checker.sv
// tb_alu_result_checker: directed and randomized checks of alu_result_checker against a transaction-level model
module tb_alu_result_checker;
  logic        Clk = 1'b0, Rst = 1'b1, Clear = 1'b0, InValid = 1'b0, Zero = 1'b0;
  logic [4:0]  ALUControl = 5'd0;
  logic [31:0] A = 32'd0, B = 32'd0, ALUResult = 32'd0;
  logic [15:0] PassCount, FailCount, UnknownCount;
  logic        Mismatch, Failed;
  logic [4:0]  FirstFailOp;
  logic [31:0] FirstFailGot, FirstFailExp;
  logic [3:0]  pass4, fail4, unk4;
  logic        mis4, failed4;
  logic [4:0]  ff_op4;
  logic [31:0] ff_got4, ff_exp4;
  int errors = 0, checks = 0;
  // model: the transaction waiting one edge before it is judged, plus visible results
  logic        m_v;
  logic [4:0]  m_op;
  logic [31:0] m_a, m_b, m_r;
  logic        m_z;
  logic [15:0] m_pass, m_fail, m_unk;
  logic        m_mis, m_failed;
  logic [4:0]  m_ffop;
  logic [31:0] m_ffgot, m_ffexp;

  alu_result_checker dut (
    .Clk(Clk), .Rst(Rst), .Clear(Clear), .InValid(InValid), .ALUControl(ALUControl),
    .A(A), .B(B), .ALUResult(ALUResult), .Zero(Zero),
    .PassCount(PassCount), .FailCount(FailCount), .UnknownCount(UnknownCount),
    .Mismatch(Mismatch), .Failed(Failed), .FirstFailOp(FirstFailOp),
    .FirstFailGot(FirstFailGot), .FirstFailExp(FirstFailExp)
  );

  alu_result_checker #(.CNT_WIDTH(4)) dut4 (
    .Clk(Clk), .Rst(Rst), .Clear(Clear), .InValid(InValid), .ALUControl(ALUControl),
    .A(A), .B(B), .ALUResult(ALUResult), .Zero(Zero),
    .PassCount(pass4), .FailCount(fail4), .UnknownCount(unk4),
    .Mismatch(mis4), .Failed(failed4), .FirstFailOp(ff_op4),
    .FirstFailGot(ff_got4), .FirstFailExp(ff_exp4)
  );

  always #5 Clk = ~Clk;

  function automatic logic [31:0] ref_exp(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      5'b00000: return a & b;
      5'b00001: return a | b;
      5'b00010: return a + b;
      5'b00110: return a - b;
      5'b00111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default:  return 32'd0;
    endcase
  endfunction

  function automatic logic ref_known(input logic [4:0] op);
    return op == 5'd0 || op == 5'd1 || op == 5'd2 || op == 5'd6 || op == 5'd7;
  endfunction

  function automatic logic [3:0] sat4(input logic [15:0] v);
    return v > 16'd15 ? 4'hF : v[3:0];
  endfunction

  task automatic model_zero();
    m_v = 0; m_op = 0; m_a = 0; m_b = 0; m_r = 0; m_z = 0;
    m_pass = 0; m_fail = 0; m_unk = 0; m_mis = 0; m_failed = 0;
    m_ffop = 0; m_ffgot = 0; m_ffexp = 0;
  endtask

  // one clock: drive at negedge, advance the model at the edge, return at the next negedge
  task automatic cyc(input logic v, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] r, input logic z, input logic clr);
    logic [31:0] e;
    logic bad;
    InValid = v; ALUControl = op; A = a; B = b; ALUResult = r; Zero = z; Clear = clr;
    @(posedge Clk);
    if (clr) model_zero();
    else begin
      m_mis = 0;
      if (m_v) begin
        e = ref_exp(m_op, m_a, m_b);
`ifdef ALU_CHECK_ZERO_EN
        bad = (m_r != e) || (m_z != (e == 0));
`else
        bad = m_r != e;
`endif
        if (!ref_known(m_op)) begin
          if (m_unk != 16'hFFFF) m_unk++;
        end else if (bad) begin
          if (m_fail != 16'hFFFF) m_fail++;
          m_mis = 1;
          if (!m_failed) begin m_failed = 1; m_ffop = m_op; m_ffgot = m_r; m_ffexp = e; end
        end else if (m_pass != 16'hFFFF) m_pass++;
      end
      m_v = v; m_op = op; m_a = a; m_b = b; m_r = r; m_z = z;
    end
    @(negedge Clk);
    InValid = 0; Clear = 0;
  endtask

  task automatic idle();
    cyc(0, 5'd0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_clear();
    cyc(0, 5'd0, 0, 0, 0, 0, 1);
  endtask

  task automatic test_reset();
    model_zero();
    #2;
    checks++; if (PassCount !== 0 || FailCount !== 0 || UnknownCount !== 0) begin errors++; $display("FAIL reset_counts got %0d/%0d/%0d want 0/0/0", PassCount, FailCount, UnknownCount); end
    checks++; if (Mismatch !== 0 || Failed !== 0) begin errors++; $display("FAIL reset_flags got mis=%b failed=%b want 0/0", Mismatch, Failed); end
    checks++; if (FirstFailOp !== 0 || FirstFailGot !== 0 || FirstFailExp !== 0) begin errors++; $display("FAIL reset_capture got %h/%h/%h want 0", FirstFailOp, FirstFailGot, FirstFailExp); end
    @(negedge Clk); @(negedge Clk);
    Rst = 0;
    idle();
    checks++; if (PassCount !== 0 || Mismatch !== 0) begin errors++; $display("FAIL post_reset got pass=%0d mis=%b want 0/0", PassCount, Mismatch); end
  endtask

  task automatic test_pass();
    do_clear();
    cyc(1, 5'b00010, 15, 10, 25, 0, 0);
    checks++; if (PassCount !== 0) begin errors++; $display("FAIL latency_e0 got %0d want 0", PassCount); end
    cyc(1, 5'b00000, 2, 2, 2, 0, 0);
    checks++; if (PassCount !== 1) begin errors++; $display("FAIL latency_e1 got %0d want 1", PassCount); end
    cyc(1, 5'b00001, 15, 0, 15, 0, 0);
    idle(); idle();
    checks++; if (PassCount !== 3) begin errors++; $display("FAIL pass_count got %0d want 3", PassCount); end
    checks++; if (FailCount !== 0 || Failed !== 0) begin errors++; $display("FAIL pass_nofail got fail=%0d failed=%b want 0/0", FailCount, Failed); end
  endtask

  task automatic test_sub_slt();
    do_clear();
    cyc(1, 5'b00110, 5, 15, 32'hFFFFFFF6, 0, 0);
    cyc(1, 5'b00111, 32'hFFFFFFFF, 0, 1, 0, 0);
    cyc(1, 5'b00111, 15, 0, 1, 0, 0);
    idle(); idle();
    checks++; if (PassCount !== 2 || FailCount !== 1) begin errors++; $display("FAIL subslt_counts got %0d/%0d want 2/1", PassCount, FailCount); end
    checks++; if (FirstFailExp !== 0 || FirstFailGot !== 1 || FirstFailOp !== 5'b00111) begin errors++; $display("FAIL subslt_capture got op=%b got=%h exp=%h want 00111/1/0", FirstFailOp, FirstFailGot, FirstFailExp); end
  endtask

  task automatic test_sticky();
    int pulses = 0;
    do_clear();
    cyc(1, 5'b00010, 2, 2, 5, 0, 0);
    pulses += Mismatch;
    cyc(1, 5'b00001, 1, 2, 0, 0, 0);
    checks++; if (Mismatch !== 1) begin errors++; $display("FAIL sticky_mis1 got %b want 1", Mismatch); end
    pulses += Mismatch;
    idle();
    checks++; if (Mismatch !== 1) begin errors++; $display("FAIL sticky_mis2 got %b want 1", Mismatch); end
    pulses += Mismatch;
    idle();
    pulses += Mismatch;
    checks++; if (pulses != 2) begin errors++; $display("FAIL sticky_pulses got %0d want 2", pulses); end
    checks++; if (FailCount !== 2 || Failed !== 1) begin errors++; $display("FAIL sticky_count got %0d/%b want 2/1", FailCount, Failed); end
    checks++; if (FirstFailOp !== 5'b00010 || FirstFailGot !== 5 || FirstFailExp !== 4) begin errors++; $display("FAIL sticky_capture got %b/%0d/%0d want 00010/5/4", FirstFailOp, FirstFailGot, FirstFailExp); end
  endtask

  task automatic test_unknown_clear();
    do_clear();
    cyc(1, 5'b01111, 3, 4, 9, 0, 0);
    idle(); idle();
    checks++; if (UnknownCount !== 1 || PassCount !== 0 || FailCount !== 0) begin errors++; $display("FAIL unknown got %0d/%0d/%0d want 1/0/0", UnknownCount, PassCount, FailCount); end
    cyc(1, 5'b00010, 2, 2, 5, 0, 0);
    cyc(1, 5'b00010, 1, 1, 2, 0, 1);
    checks++; if (FailCount !== 0 || UnknownCount !== 0 || Mismatch !== 0 || Failed !== 0 || FirstFailGot !== 0) begin errors++; $display("FAIL clear_priority got fail=%0d unk=%0d mis=%b failed=%b", FailCount, UnknownCount, Mismatch, Failed); end
    idle(); idle();
    checks++; if (FailCount !== 0 || PassCount !== 0) begin errors++; $display("FAIL clear_drop got %0d/%0d want 0/0", PassCount, FailCount); end
  endtask

  task automatic test_zero();
    do_clear();
    cyc(1, 5'b00110, 7, 7, 0, 0, 0);
    idle(); idle();
`ifdef ALU_CHECK_ZERO_EN
    checks++; if (FailCount !== 1 || PassCount !== 0) begin errors++; $display("FAIL zero_check got pass=%0d fail=%0d want 0/1", PassCount, FailCount); end
`else
    checks++; if (PassCount !== 1 || FailCount !== 0) begin errors++; $display("FAIL zero_check got pass=%0d fail=%0d want 1/0", PassCount, FailCount); end
`endif
  endtask

  task automatic test_reset_mid();
    do_clear();
    cyc(1, 5'b00010, 1, 1, 2, 0, 0);
    cyc(1, 5'b00010, 3, 1, 4, 0, 0);
    checks++; if (PassCount !== 1) begin errors++; $display("FAIL rstmid_pre got %0d want 1", PassCount); end
    #2 Rst = 1;
    #1;
    checks++; if (PassCount !== 0 || Failed !== 0 || Mismatch !== 0) begin errors++; $display("FAIL rstmid_async got pass=%0d failed=%b mis=%b want 0", PassCount, Failed, Mismatch); end
    #1 Rst = 0;
    model_zero();
    @(negedge Clk);
    idle(); idle();
    checks++; if (PassCount !== 0 || FailCount !== 0) begin errors++; $display("FAIL rstmid_lost got %0d/%0d want 0/0", PassCount, FailCount); end
  endtask

  task automatic test_saturation();
    do_clear();
    for (int i = 0; i < 20; i++) cyc(1, 5'b00000, 32'hFF, 32'h0F, 32'h0F, 0, 0);
    idle(); idle();
    checks++; if (pass4 !== 4'd15) begin errors++; $display("FAIL sat4 got %0d want 15", pass4); end
    checks++; if (PassCount !== 20) begin errors++; $display("FAIL sat16 got %0d want 20", PassCount); end
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [31:0] a, b, e, r;
    logic z;
    do_clear();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 5))
        0: op = 5'b00000; 1: op = 5'b00001; 2: op = 5'b00010;
        3: op = 5'b00110; 4: op = 5'b00111; default: op = 5'($urandom);
      endcase
      a = $urandom;
      b = ($urandom_range(0, 4) == 0) ? a : $urandom;
      e = ref_exp(op, a, b);
      r = ($urandom_range(0, 3) == 0) ? $urandom : e;
      z = ($urandom_range(0, 7) == 0) ? (e != 0) : (e == 0);
      cyc($urandom_range(0, 3) != 0, op, a, b, r, z, $urandom_range(0, 59) == 0);
      checks++; if (PassCount !== m_pass || FailCount !== m_fail || UnknownCount !== m_unk) begin errors++; $display("FAIL rand_counts[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, PassCount, FailCount, UnknownCount, m_pass, m_fail, m_unk); end
      checks++; if (Mismatch !== m_mis || Failed !== m_failed) begin errors++; $display("FAIL rand_flags[%0d] got %b/%b want %b/%b", i, Mismatch, Failed, m_mis, m_failed); end
      checks++; if (FirstFailOp !== m_ffop || FirstFailGot !== m_ffgot || FirstFailExp !== m_ffexp) begin errors++; $display("FAIL rand_capture[%0d] got %b/%h/%h want %b/%h/%h", i, FirstFailOp, FirstFailGot, FirstFailExp, m_ffop, m_ffgot, m_ffexp); end
      checks++; if (pass4 !== sat4(m_pass) || fail4 !== sat4(m_fail) || unk4 !== sat4(m_unk) || mis4 !== m_mis || failed4 !== m_failed || ff_op4 !== m_ffop || ff_got4 !== m_ffgot || ff_exp4 !== m_ffexp) begin errors++; $display("FAIL rand_w4[%0d] got %0d/%0d/%0d want %0d/%0d/%0d", i, pass4, fail4, unk4, sat4(m_pass), sat4(m_fail), sat4(m_unk)); end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_sub_slt();
    test_sticky();
    test_unknown_clear();
    test_zero();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
